addsub_arbiter: RTL and testbench

//  Shares one addsub32 (32-bit ripple add/sub, outputs sum/cout/V) among NREQ requesters.

---
 rtl/addsub_arb_pkg.sv | 23 ++
 rtl/addsub32.sv | 27 ++
 rtl/addsub_arbiter_rr.sv | 33 +++
 rtl/addsub_arbiter.sv | 160 ++++++++++++++++
 tb/tb_addsub_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_arb_pkg.sv
// rtl/addsub_arb_pkg.sv - shared types and helpers for the add/sub arbiter
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int OPCNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] v);
        logic [OPCNT_W-1:0] r;
        if (v == {OPCNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub32.sv
// rtl/addsub32.sv - 32-bit ripple-carry adder/subtractor with carry-out and signed overflow
module addsub32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] sum_o,
    output logic        cout_o,
    output logic        v_o
);

    logic [31:0] bx;
    logic [32:0] c;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in
    assign bx   = b_i ^ {32{sub_i}};
    assign c[0] = sub_i;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ bx[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
    end

    assign cout_o = c[32];
    // Signed overflow: carry into the sign bit differs from carry out of it
    assign v_o    = c[32] ^ c[31];

endmodule

// File: rtl/addsub_arbiter_rr.sv
// rtl/addsub_arbiter_rr.sv - round-robin picker: first request at or after the pointer
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    // Walk the requesters starting at the pointer, wrapping, and keep the first hit
    always_comb begin
        int          j;
        logic [IDW-1:0] jj;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j  = (int'(ptr_i) + k) % NREQ;
            jj = IDW'(j);
            if (!any_o && req_i[jj]) begin
                any_o       = 1'b1;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - shares one addsub32 among NREQ requesters with round-robin grant
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 32,   // must match the addsub32 datapath width
    parameter int SETTLE_CYC = 2,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  busy,
    output logic [OPCNT_W-1:0]    op_count
);

    // cnt only has to hold SETTLE_CYC-1
    localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e               state_q;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]      cnt_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 sub_q;
    logic [IDW-1:0]       id_q;
    logic                 rsp_valid_q;
    logic [IDW-1:0]       rsp_id_q;
    logic [WIDTH-1:0]     rsp_sum_q;
    logic                 rsp_cout_q;
    logic                 rsp_ovf_q;
    logic [OPCNT_W-1:0]   op_count_q, op_count_d;

    logic [NREQ-1:0]      arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;

    logic [WIDTH-1:0]     a_sel, b_sel;
    logic                 sub_sel;

    logic [WIDTH-1:0]     sum_w;
    logic                 cout_w;
    logic                 v_w;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Operands seen by the adder come only from the latched copy, never from the live bus
    addsub32 u_addsub (
        .a_i    (a_q),
        .b_i    (b_q),
        .sub_i  (sub_q),
        .sum_o  (sum_w),
        .cout_o (cout_w),
        .v_o    (v_w)
    );

    // Route the granted requester's operands to the capture registers
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                a_sel   = req_a[i*WIDTH +: WIDTH];
                b_sel   = req_b[i*WIDTH +: WIDTH];
                sub_sel = req_sub[i];
            end
        end
    end

    // Next pointer sits just past the winner; next completion count saturates
    always_comb begin
        rr_ptr_d   = IDW'((int'(arb_idx) + 1) % NREQ);
        op_count_d = sat_inc(op_count_q);
    end

    // Control FSM with all response state registered; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        a_q      <= a_sel;
                        b_q      <= b_sel;
                        sub_q    <= sub_sel;
                        id_q     <= arb_idx;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= CNTW'(SETTLE_CYC - 1);
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_sum_q   <= sum_w;
                        rsp_cout_q  <= cout_w;
                        rsp_ovf_q   <= v_w;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Grant is offered only while idle and out of reset, so it is one-hot or zero
    assign req_ready = (state_q == IDLE && rst_n) ? arb_grant : '0;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed and randomized checks for addsub_arbiter
module tb_addsub_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 32;
    localparam int SETTLE = 2;
    localparam int IDW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ovf;
    logic                  busy;
    logic [15:0]           op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(
        .NREQ       (NREQ),
        .WIDTH      (WIDTH),
        .SETTLE_CYC (SETTLE),
        .IDW        (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Reference: {ovf, cout, sum} from the arithmetic definition
    function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] full;
        logic        ovf;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + 33'd1;
            ovf  = (a[31] != b[31]) && (full[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        end
        return {ovf, full};
    endfunction

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub);
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
        req_sub[r]              = sub;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if ({rsp_valid, busy, rsp_cout, rsp_ovf} !== 4'b0 || req_ready !== 4'b0) begin
            errors++; $display("FAIL reset_flags got v=%b busy=%b c=%b o=%b rdy=%b want all 0", rsp_valid, busy, rsp_cout, rsp_ovf, req_ready);
        end
        checks++;
        if (rsp_sum !== 32'h0 || rsp_id !== 2'd0 || op_count !== 16'd0) begin
            errors++; $display("FAIL reset_data got sum=%h id=%0d cnt=%0d want 0", rsp_sum, rsp_id, op_count);
        end
        checks++;
        // One complete op leaves non-zero response registers behind
        set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_valid = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (SETTLE) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        // Second op interrupted by reset while all requesters keep asking
        set_req(3, 32'h1234, 32'h5678, 1'b0);
        req_valid = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({rsp_valid, busy, rsp_cout, rsp_ovf} !== 4'b0 || req_ready !== 4'b0) begin
                errors++; $display("FAIL midreset_flags cyc%0d got v=%b busy=%b c=%b o=%b rdy=%b want 0", i, rsp_valid, busy, rsp_cout, rsp_ovf, req_ready);
            end
            checks++;
            if (rsp_sum !== 32'h0 || rsp_id !== 2'd0 || op_count !== 16'd0) begin
                errors++; $display("FAIL midreset_data cyc%0d got sum=%h id=%0d cnt=%0d want 0", i, rsp_sum, rsp_id, op_count);
            end
            checks++;
        end
        rst_n     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL aborted_rsp cyc%0d got rsp_valid=%b want 0", i, rsp_valid);
            end
            checks++;
        end
    endtask

    task automatic test_add_overflow();
        do_reset();
        set_req(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0100;
        #1;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL ovf_grant got %b want 0100", req_ready);
        end
        checks++;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        if (busy !== 1'b1 || req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_exec got busy=%b rdy=%b v=%b want 1 0000 0", busy, req_ready, rsp_valid);
        end
        checks++;
        repeat (SETTLE - 1) @(negedge clk);
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_early got rsp_valid=%b want 0", rsp_valid);
        end
        checks++;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL ovf_latency got v=%b id=%0d want 1 2", rsp_valid, rsp_id);
        end
        checks++;
        if (rsp_sum !== 32'h8000_0000 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_result got %h c=%b o=%b want 80000000 0 1", rsp_sum, rsp_cout, rsp_ovf);
        end
        checks++;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_done got v=%b cnt=%0d busy=%b want 0 1 0", rsp_valid, op_count, busy);
        end
        checks++;
    endtask

    task automatic test_sub();
        logic [31:0] va[2];
        logic [31:0] vb[2];
        logic [31:0] vs[2];
        logic        vc[2];
        va[0] = 32'h5; vb[0] = 32'h5; vs[0] = 32'h0;         vc[0] = 1'b1;
        va[1] = 32'h0; vb[1] = 32'h1; vs[1] = 32'hFFFF_FFFF; vc[1] = 1'b0;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            set_req(0, va[t], vb[t], 1'b1);
            req_valid = 4'b0001;
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            repeat (SETTLE) @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
                errors++; $display("FAIL sub%0d_valid got v=%b id=%0d want 1 0", t, rsp_valid, rsp_id);
            end
            checks++;
            if (rsp_sum !== vs[t] || rsp_cout !== vc[t] || rsp_ovf !== 1'b0) begin
                errors++; $display("FAIL sub%0d_result got %h c=%b o=%b want %h %b 0", t, rsp_sum, rsp_cout, rsp_ovf, vs[t], vc[t]);
            end
            checks++;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int ids[5];
        int when[5];
        int nresp  = 0;
        int grants = 0;
        int cyc    = 0;
        logic drop = 1'b0;
        logic [1:0] want_id[5];
        want_id[0] = 2'd0; want_id[1] = 2'd1; want_id[2] = 2'd2; want_id[3] = 2'd3; want_id[4] = 2'd0;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(16*i + 1), 32'(i), 1'b0);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        while (nresp < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (drop) req_valid = '0;
            if (req_ready != 4'b0) begin
                grants++;
                if (grants == 5) drop = 1'b1;
            end
            if (rsp_valid) begin
                ids[nresp]  = int'(rsp_id);
                when[nresp] = cyc;
                if (rsp_sum !== 32'(17*int'(rsp_id) + 1)) begin
                    errors++; $display("FAIL rr_sum%0d got %h want %h", nresp, rsp_sum, 32'(17*int'(rsp_id) + 1));
                end
                checks++;
                nresp++;
            end
        end
        if (nresp != 5) begin
            errors++; $display("FAIL rr_timeout got %0d responses want 5", nresp);
        end
        checks++;
        for (int i = 0; i < nresp; i++) begin
            if (ids[i] != int'(want_id[i])) begin
                errors++; $display("FAIL rr_order%0d got id=%0d want %0d", i, ids[i], want_id[i]);
            end
            checks++;
        end
        if (nresp >= 2) begin
            if (when[1] - when[0] != SETTLE + 2) begin
                errors++; $display("FAIL rr_throughput got %0d cycles want %0d", when[1] - when[0], SETTLE + 2);
            end
            checks++;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        if (op_count !== 16'd5 || busy !== 1'b0) begin
            errors++; $display("FAIL rr_opcount got cnt=%0d busy=%b want 5 0", op_count, busy);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        req_valid = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1011;
        repeat (SETTLE) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'h7777_7788 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b id=%0d sum=%h c=%b o=%b want 1 1 77777788 0 0", i, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf);
            end
            checks++;
            if (req_ready !== 4'b0) begin
                errors++; $display("FAIL bp_ready%0d got %b want 0000", i, req_ready);
            end
            checks++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        if (rsp_valid !== 1'b0 || op_count !== 16'd1) begin
            errors++; $display("FAIL bp_handshake got v=%b cnt=%0d want 0 1", rsp_valid, op_count);
        end
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_next_grant got %b want 1000", req_ready);
        end
        checks++;
        req_valid = '0;
    endtask

    task automatic test_random();
        localparam int NOPS   = 5000;
        localparam int RST_OP = 2500;
        int          ptr      = 0;
        int          done     = 0;
        int          g;
        int          j;
        int          waitc;
        logic        force_all = 1'b0;
        logic [3:0]  mask;
        logic [3:0]  exp_rdy;
        logic [31:0] ra[4];
        logic [31:0] rb[4];
        logic        rs[4];
        logic [33:0] exp;
        do_reset();
        for (int n = 0; n < NOPS; n++) begin
            @(negedge clk);
            mask = force_all ? 4'hF : 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                ra[i] = $urandom;
                rb[i] = $urandom;
                rs[i] = 1'($urandom_range(0, 1));
                set_req(i, ra[i], rb[i], rs[i]);
            end
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (ptr + k) % NREQ;
                if (g < 0 && mask[j]) g = j;
            end
            if (force_all && g != 0) begin
                errors++; $display("FAIL rnd_post_reset_ptr got model grant %0d want 0", g);
            end
            if (force_all) checks++;
            force_all = 1'b0;
            exp_rdy   = 4'(1 << g);
            req_valid = mask;
            #1;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_grant op%0d got %b want %b", n, req_ready, exp_rdy);
            end
            checks++;
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            ptr = (g + 1) % NREQ;
            if (n == RST_OP) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                ptr   = 0;
                done  = 0;
                force_all = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                        errors++; $display("FAIL rnd_abort cyc%0d got v=%b busy=%b want 0 0", i, rsp_valid, busy);
                    end
                    checks++;
                end
                continue;
            end
            waitc = 0;
            while (rsp_valid !== 1'b1 && waitc < 10) begin
                @(negedge clk);
                waitc++;
            end
            if (rsp_valid !== 1'b1) begin
                errors++; $display("FAIL rnd_timeout op%0d got no response want rsp_valid", n);
            end
            checks++;
            exp = ref_op(ra[g], rb[g], rs[g]);
            if (rsp_id !== 2'(g) || rsp_sum !== exp[31:0] || rsp_cout !== exp[32] || rsp_ovf !== exp[33]) begin
                errors++; $display("FAIL rnd_result op%0d got id=%0d %h c=%b o=%b want %0d %h %b %b", n, rsp_id, rsp_sum, rsp_cout, rsp_ovf, g, exp[31:0], exp[32], exp[33]);
            end
            checks++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== exp[31:0]) begin
                errors++; $display("FAIL rnd_stall op%0d got v=%b sum=%h want 1 %h", n, rsp_valid, rsp_sum, exp[31:0]);
            end
            checks++;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            done++;
        end
        if (op_count !== 16'(done)) begin
            errors++; $display("FAIL rnd_opcount got %0d want %0d", op_count, done);
        end
        checks++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
